// File: rtl/iq_pkg.sv
// Shared definitions for the I/Q pair packer: channel tags, FSM states, pair word layout.
// Latency: none (declarations only).
// Backpressure: not applicable.
package iq_pkg;

  // Channel tag carried on s_tid.
  localparam logic CH_I = 1'b0;
  localparam logic CH_Q = 1'b1;

  // Pairing FSM: waiting for the I half, or holding an I and waiting for its Q.
  typedef enum logic {
    WAIT_I = 1'b0,
    WAIT_Q = 1'b1
  } state_t;

  // Pair word layout: I in the low half, Q in the high half, tlast above both
  // when the word travels through the output buffer.
  localparam int I_OFS = 0;

  function automatic int q_ofs(input int dw);
    return dw;
  endfunction

  function automatic int last_ofs(input int dw);
    return 2 * dw;
  endfunction

  localparam logic [15:0] ERR_MAX = 16'hFFFF;

endpackage

// File: rtl/iq_skid_fifo.sv
// Two-entry register FIFO, in order; head word is visible on data_out while valid.
// Latency: a push is visible on data_out the cycle after it is written into an empty FIFO.
// Backpressure: full flags occupancy 2; a push and a pop in the same cycle are both honoured.
// Ports: clk/rst (async active-high), push/data_in write side, pop/data_out read side,
//        full/empty occupancy flags, valid = head word present.
module iq_skid_fifo #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] data_in,
  input  logic         pop,
  output logic [W-1:0] data_out,
  output logic         full,
  output logic         empty,
  output logic         valid
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign valid    = !empty;
  assign do_pop   = pop && !empty;
  // When full, the slot under wr_ptr is the head being popped this cycle, so
  // overwriting it is safe.
  assign do_push  = push && (!full || do_pop);
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= !wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= !rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/iq_pair_packer.sv
// Re-pairs an interleaved tid-tagged I/Q sample stream into framed {Q, I} words, counting misalignment.
// Latency: a Q beat accepted in cycle N appears on m_tdata in cycle N+1 when the output buffer is empty.
// Backpressure: s_tready = ce && buffer not full (registered state only); buffer keeps draining when ce=0.
// Ports: aclk/areset (async active-high); ce input-side enable; s_t* sample input (tid 0=I, 1=Q);
//        m_t* framed pair output, tlast every FRAME_LEN pairs; err_clr clears err_count/sync_lost.
module iq_pair_packer
  import iq_pkg::*;
#(
  parameter int DW        = 16,
  parameter int FRAME_LEN = 1024,
  parameter int FW        = 16
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          ce,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tid,
  input  logic          s_tvalid,
  output logic          s_tready,
  output logic [2*DW-1:0] m_tdata,
  output logic          m_tlast,
  output logic          m_tvalid,
  input  logic          m_tready,
  input  logic          err_clr,
  output logic [15:0]   err_count,
  output logic          sync_lost
);

  localparam int PW     = 2 * DW;
  localparam int EW     = PW + 1;
  localparam int Q_LSB  = q_ofs(DW);
  localparam int L_BIT  = last_ofs(DW);

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] i_hold;
  logic [FW-1:0] frame_idx;
  logic          run;
  logic          accept;
  logic          push_pair;
  logic          load_i;
  logic          mis_evt;
  logic          frame_end;
  logic          buf_full;
  logic          buf_empty;
  logic          buf_valid;
  logic [EW-1:0] buf_in;
  logic [EW-1:0] buf_out;

  // run holds s_tready low while in reset and rises on the first clock after release.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) run <= 1'b0;
    else        run <= 1'b1;
  end

  assign s_tready = run && ce && !buf_full;
  assign accept   = s_tvalid && s_tready;

  // State register: only an accepted beat moves the FSM, so ce=0 freezes it.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)      state <= WAIT_I;
    else if (accept) state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_I:  if (s_tid == CH_I) state_nxt = WAIT_Q;
      WAIT_Q:  if (s_tid == CH_Q) state_nxt = WAIT_I;
      default: state_nxt = WAIT_I;
    endcase
  end

  // Output decode: orphan Q is dropped, a second I replaces the held one.
  always_comb begin
    push_pair = 1'b0;
    load_i    = 1'b0;
    mis_evt   = 1'b0;
    if (accept) begin
      case (state)
        WAIT_I: begin
          if (s_tid == CH_I) load_i  = 1'b1;
          else               mis_evt = 1'b1;
        end
        WAIT_Q: begin
          if (s_tid == CH_Q) begin
            push_pair = 1'b1;
          end else begin
            load_i  = 1'b1;
            mis_evt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign frame_end = (frame_idx == FW'(FRAME_LEN - 1));

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      i_hold    <= '0;
      frame_idx <= '0;
    end else begin
      if (load_i) i_hold <= s_tdata;
      if (push_pair) frame_idx <= frame_end ? '0 : frame_idx + FW'(1);
    end
  end

  // Clear dominates a same-cycle event.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err_count <= '0;
      sync_lost <= 1'b0;
    end else if (err_clr) begin
      err_count <= '0;
      sync_lost <= 1'b0;
    end else if (mis_evt) begin
      sync_lost <= 1'b1;
      if (err_count != ERR_MAX) err_count <= err_count + 16'd1;
    end
  end

  always_comb begin
    buf_in                = '0;
    buf_in[L_BIT]         = frame_end;
    buf_in[Q_LSB +: DW]   = s_tdata;
    buf_in[I_OFS +: DW]   = i_hold;
  end

  iq_skid_fifo #(
    .W(EW)
  ) u_buf (
    .clk      (aclk),
    .rst      (areset),
    .push     (push_pair),
    .data_in  (buf_in),
    .pop      (m_tready && !buf_empty),
    .data_out (buf_out),
    .full     (buf_full),
    .empty    (buf_empty),
    .valid    (buf_valid)
  );

  assign m_tvalid = buf_valid;
  assign m_tdata  = buf_out[PW-1:0];
  assign m_tlast  = buf_out[L_BIT];

endmodule

// File: tb/tb_iq_pair_packer.sv
// Bench for iq_pair_packer with FRAME_LEN=4: directed scenarios plus randomized traffic
// checked against a pairing model kept here (pending-I slot, pair number, error tally).
// Inputs change 1 time unit after the rising edge; the model and output capture run on the falling edge.
module tb_iq_pair_packer;

  localparam int DW = 16;
  localparam int FL = 4;
  localparam int FW = 16;

  typedef logic [2*DW:0] pair_t;  // {tlast, Q, I}

  logic          aclk     = 1'b0;
  logic          areset   = 1'b1;
  logic          ce       = 1'b1;
  logic [DW-1:0] s_tdata  = '0;
  logic          s_tid    = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [2*DW-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          err_clr  = 1'b0;
  logic [15:0]   err_count;
  logic          sync_lost;

  int vectors     = 0;
  int miscompares = 0;
  int ready_mode  = 1;  // 0 low, 1 high, 2 random
  int ce_mode     = 1;  // 1 high, 2 random
  int cmp_base    = 0;

  pair_t         exp_q[$];
  pair_t         obs_q[$];
  bit            has_i      = 1'b0;
  logic [DW-1:0] i_val      = '0;
  int            pair_no    = 0;
  int            model_err  = 0;
  bit            model_sync = 1'b0;
  bit            m_ev;

  iq_pair_packer #(.DW(DW), .FRAME_LEN(FL), .FW(FW)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .ce        (ce),
    .s_tdata   (s_tdata),
    .s_tid     (s_tid),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .m_tdata   (m_tdata),
    .m_tlast   (m_tlast),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .err_clr   (err_clr),
    .err_count (err_count),
    .sync_lost (sync_lost)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    #1;
    m_tready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode != 0);
    ce       = (ce_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Reference model: a Q completes the pending I into a pair, a Q with nothing pending
  // or an I on top of a pending I is a misalignment event.
  always @(negedge aclk) begin
    if (areset) begin
      has_i = 1'b0; pair_no = 0; model_err = 0; model_sync = 1'b0;
      exp_q.delete(); obs_q.delete();
    end else begin
      m_ev = 1'b0;
      if (s_tvalid && s_tready) begin
        if (s_tid) begin
          if (has_i) begin
            exp_q.push_back({pair_no == FL - 1, s_tdata, i_val});
            pair_no = (pair_no + 1) % FL;
            has_i = 1'b0;
          end else m_ev = 1'b1;
        end else begin
          if (has_i) m_ev = 1'b1;
          i_val = s_tdata;
          has_i = 1'b1;
        end
      end
      if (err_clr) begin
        model_err = 0; model_sync = 1'b0;
      end else if (m_ev) begin
        model_sync = 1'b1;
        if (model_err < 65535) model_err++;
      end
      if (m_tvalid && m_tready) obs_q.push_back({m_tlast, m_tdata});
    end
  end

  task automatic send_beat(input logic tid, input logic [DW-1:0] d);
    int n;
    n = 0;
    s_tvalid = 1'b1; s_tid = tid; s_tdata = d;
    @(negedge aclk);
    while (!s_tready && n < 300) begin @(negedge aclk); n++; end
    if (!s_tready) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout s_tready=%0b required 1", s_tready);
    end
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    s_tvalid = 1'b0; ready_mode = 1; ce_mode = 1;
    repeat (10) @(posedge aclk);
    #1;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge aclk); #1;
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    vectors++; if (s_tready !== 1'b0) begin miscompares++; $display("FAIL rst_s_tready got %0b required 0", s_tready); end
    vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL rst_m_tvalid got %0b required 0", m_tvalid); end
    vectors++; if (m_tdata !== '0) begin miscompares++; $display("FAIL rst_m_tdata got %h required 0", m_tdata); end
    vectors++; if (m_tlast !== 1'b0) begin miscompares++; $display("FAIL rst_m_tlast got %0b required 0", m_tlast); end
    vectors++; if (err_count !== 16'd0) begin miscompares++; $display("FAIL rst_err_count got %0d required 0", err_count); end
    vectors++; if (sync_lost !== 1'b0) begin miscompares++; $display("FAIL rst_sync_lost got %0b required 0", sync_lost); end
    @(posedge aclk); #1;
    areset = 1'b0;
    @(posedge aclk); #1;
    vectors++; if (s_tready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready got %0b required 1", s_tready); end
  endtask

  task automatic test_clean_stream();
    int base;
    base = cmp_base;
    for (int k = 1; k <= 16; k++) send_beat(k % 2 == 0, DW'(k));
    drain();
    vectors++; if (obs_q.size() !== base + 8) begin miscompares++; $display("FAIL clean_count got %0d required %0d", obs_q.size() - base, 8); end
    if (obs_q.size() > base) begin
      vectors++; if (obs_q[base] !== {1'b0, 16'd2, 16'd1}) begin miscompares++; $display("FAIL clean_first got %h required 000020001", obs_q[base]); end
    end
    for (int i = cmp_base; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL clean_pair[%0d] got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    vectors++; if (err_count !== 16'd0) begin miscompares++; $display("FAIL clean_err got %0d required 0", err_count); end
    cmp_base = exp_q.size();
  endtask

  task automatic test_latency();
    logic [DW-1:0] iv, qv;
    iv = DW'($urandom); qv = DW'($urandom);
    ready_mode = 0;
    @(posedge aclk); #1;
    send_beat(1'b0, iv);
    send_beat(1'b1, qv);
    vectors++; if (m_tvalid !== 1'b1) begin miscompares++; $display("FAIL lat_valid got %0b required 1", m_tvalid); end
    vectors++; if (m_tdata !== {qv, iv}) begin miscompares++; $display("FAIL lat_data got %h required %h", m_tdata, {qv, iv}); end
    drain();
    for (int i = cmp_base; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL lat_pair[%0d] got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    vectors++; if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL lat_count got %0d required %0d", obs_q.size(), exp_q.size()); end
    cmp_base = exp_q.size();
  endtask

  task automatic test_orphan();
    pulse_clr();
    vectors++; if (err_count !== 16'd0) begin miscompares++; $display("FAIL orphan_pre_err got %0d required 0", err_count); end
    send_beat(1'b1, 16'h0055);
    send_beat(1'b0, 16'h0010);
    send_beat(1'b1, 16'h0020);
    drain();
    vectors++; if (err_count !== 16'd1) begin miscompares++; $display("FAIL orphan_err got %0d required 1", err_count); end
    vectors++; if (sync_lost !== 1'b1) begin miscompares++; $display("FAIL orphan_sync got %0b required 1", sync_lost); end
    vectors++; if (obs_q.size() !== cmp_base + 1) begin miscompares++; $display("FAIL orphan_count got %0d required 1", obs_q.size() - cmp_base); end
    if (obs_q.size() > cmp_base) begin
      vectors++; if (obs_q[cmp_base][2*DW-1:0] !== 32'h0020_0010) begin miscompares++; $display("FAIL orphan_pair got %h required 00200010", obs_q[cmp_base][2*DW-1:0]); end
    end
    cmp_base = obs_q.size();
    pulse_clr();
    @(negedge aclk);
    vectors++; if (sync_lost !== 1'b0) begin miscompares++; $display("FAIL clr_sync got %0b required 0", sync_lost); end
    @(posedge aclk); #1;
  endtask

  task automatic test_dup_i();
    send_beat(1'b0, 16'h000A);
    send_beat(1'b0, 16'h000B);
    send_beat(1'b1, 16'h000C);
    drain();
    vectors++; if (err_count !== 16'd1) begin miscompares++; $display("FAIL dup_err got %0d required 1", err_count); end
    vectors++; if (obs_q.size() !== cmp_base + 1) begin miscompares++; $display("FAIL dup_count got %0d required 1", obs_q.size() - cmp_base); end
    for (int i = cmp_base; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL dup_pair[%0d] got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    cmp_base = exp_q.size();
    pulse_clr();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    ready_mode = 0;
    @(posedge aclk); #1;
    for (int k = 0; k < 4; k++) send_beat(k % 2 == 1, DW'($urandom));
    held = DW'($urandom);
    s_tvalid = 1'b1; s_tid = 1'b0; s_tdata = held;
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      vectors++; if (s_tready !== 1'b0) begin miscompares++; $display("FAIL bp_ready[%0d] got %0b required 0", c, s_tready); end
      if (exp_q.size() > cmp_base) begin
        vectors++; if ({m_tvalid, m_tdata} !== {1'b1, exp_q[cmp_base][2*DW-1:0]}) begin miscompares++; $display("FAIL bp_hold[%0d] got %b/%h required 1/%h", c, m_tvalid, m_tdata, exp_q[cmp_base][2*DW-1:0]); end
      end
    end
    @(posedge aclk); #1;
    ready_mode = 1;
    send_beat(1'b0, held);
    ready_mode = 2;
    for (int k = 0; k < 7; k++) send_beat(k % 2 == 0, DW'($urandom));
    drain();
    vectors++; if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL bp_count got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = cmp_base; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL bp_pair[%0d] got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    cmp_base = exp_q.size();
  endtask

  task automatic test_random();
    ce_mode = 2; ready_mode = 2;
    for (int k = 0; k < 200; k++) send_beat(1'((k % 2) ^ ($urandom_range(0, 9) == 0)), DW'($urandom));
    drain();
    vectors++; if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL rnd_count got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = cmp_base; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rnd_pair[%0d] got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    vectors++; if (err_count !== 16'(model_err)) begin miscompares++; $display("FAIL rnd_err got %0d required %0d", err_count, model_err); end
    vectors++; if (sync_lost !== model_sync) begin miscompares++; $display("FAIL rnd_sync got %0b required %0b", sync_lost, model_sync); end
    cmp_base = exp_q.size();
  endtask

  task automatic test_saturation();
    int acc, cyc;
    acc = 0; cyc = 0;
    s_tvalid = 1'b1; s_tid = 1'b1; s_tdata = DW'($urandom);
    while (acc < 65540 && cyc < 70000) begin
      @(negedge aclk);
      if (s_tready) acc++;
      cyc++;
    end
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
    vectors++; if (acc !== 65540) begin miscompares++; $display("FAIL sat_accepted got %0d required 65540", acc); end
    repeat (2) @(posedge aclk);
    #1;
    vectors++; if (err_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_err got %h required ffff", err_count); end
    vectors++; if (err_count !== 16'(model_err)) begin miscompares++; $display("FAIL sat_model got %0d required %0d", err_count, model_err); end
    vectors++; if (sync_lost !== 1'b1) begin miscompares++; $display("FAIL sat_sync got %0b required 1", sync_lost); end
    s_tvalid = 1'b1; s_tid = 1'b1; err_clr = 1'b1;
    @(negedge aclk);
    vectors++; if (s_tready !== 1'b1) begin miscompares++; $display("FAIL clr_evt_ready got %0b required 1", s_tready); end
    @(posedge aclk); #1;
    s_tvalid = 1'b0; err_clr = 1'b0;
    @(negedge aclk);
    vectors++; if (err_count !== 16'd0) begin miscompares++; $display("FAIL clr_evt_err got %0d required 0", err_count); end
    vectors++; if (sync_lost !== 1'b0) begin miscompares++; $display("FAIL clr_evt_sync got %0b required 0", sync_lost); end
    @(posedge aclk); #1;
  endtask

  task automatic test_reset_mid();
    ready_mode = 0;
    @(posedge aclk); #1;
    send_beat(1'b0, DW'($urandom));
    send_beat(1'b1, DW'($urandom));
    send_beat(1'b0, DW'($urandom));
    @(negedge aclk);
    vectors++; if (m_tvalid !== 1'b1) begin miscompares++; $display("FAIL mid_buffered got %0b required 1", m_tvalid); end
    @(posedge aclk); #1;
    areset = 1'b1;
    @(negedge aclk);
    vectors++; if ({s_tready, m_tvalid, m_tlast} !== 3'b000) begin miscompares++; $display("FAIL mid_rst_flags got %b required 000", {s_tready, m_tvalid, m_tlast}); end
    vectors++; if (m_tdata !== '0) begin miscompares++; $display("FAIL mid_rst_data got %h required 0", m_tdata); end
    vectors++; if ({err_count, sync_lost} !== 17'd0) begin miscompares++; $display("FAIL mid_rst_err got %0d/%0b required 0/0", err_count, sync_lost); end
    @(posedge aclk); #1;
    areset = 1'b0; cmp_base = 0; ready_mode = 1;
    @(posedge aclk); #1;
    for (int k = 0; k < 2 * FL; k++) send_beat(k % 2 == 1, DW'($urandom));
    drain();
    vectors++; if (obs_q.size() !== FL) begin miscompares++; $display("FAIL mid_count got %0d required %0d", obs_q.size(), FL); end
    if (obs_q.size() >= FL) begin
      vectors++; if ({obs_q[0][2*DW], obs_q[FL-1][2*DW]} !== 2'b01) begin miscompares++; $display("FAIL mid_frame_restart got %b required 01", {obs_q[0][2*DW], obs_q[FL-1][2*DW]}); end
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL mid_pair[%0d] got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    vectors++; if (err_count !== 16'd0) begin miscompares++; $display("FAIL mid_err got %0d required 0", err_count); end
  endtask

  initial begin
    test_reset();
    test_clean_stream();
    test_latency();
    test_orphan();
    test_dup_i();
    test_backpressure();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
